wt_l15_req_arb: RTL and testbench

WT_L15_REQ_ARB -- requirements
Module: wt_l15_req_arb

---
 rtl/wt_cache_pkg.sv | 37 +++
 rtl/wt_l15_req_arb_rr_arb_2.sv | 25 ++
 rtl/wt_l15_req_arb.sv | 134 +++++++++++++
 tb/tb_wt_l15_req_arb.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wt_cache_pkg.sv
// Shared write-through cache / L1.5 types, widths and the byte-swap helper.
package wt_cache_pkg;

  localparam int L15_TID_WIDTH = 2;
  localparam int L15_WAY_WIDTH = 3;
  localparam int L1I_WAY_WIDTH = 2;
  localparam int L1D_WAY_WIDTH = 2;

  typedef enum logic [1:0] {
    DCACHE_STORE_REQ  = 2'd0,
    DCACHE_LOAD_REQ   = 2'd1,
    DCACHE_ATOMIC_REQ = 2'd2,
    DCACHE_INT_REQ    = 2'd3
  } dcache_out_t;

  typedef enum logic [4:0] {
    L15_LOAD_RQ   = 5'b00000,
    L15_STORE_RQ  = 5'b00001,
    L15_ATOMIC_RQ = 5'b00110,
    L15_INT_RQ    = 5'b01001,
    L15_IMISS_RQ  = 5'b10000
  } l15_reqtypes_t;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_HOLD = 1'b1
  } arb_state_t;

  function automatic logic [63:0] swendian64(input logic [63:0] in);
    logic [63:0] out;
    for (int i = 0; i < 8; i++) begin
      out[i*8 +: 8] = in[(7-i)*8 +: 8];
    end
    return out;
  endfunction

endpackage

// File: rtl/wt_l15_req_arb_rr_arb_2.sv
// Two-way round-robin arbiter; req[0] = icache, req[1] = dcache.
// History flop resets to "dcache granted last" so icache wins the first tie.
module rr_arb_2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] gnt
);

  logic last_dc;

  assign gnt[1] = req[1] & (~req[0] | ~last_dc);
  assign gnt[0] = req[0] & ~gnt[1];

  // History only advances when the grant is actually taken downstream.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_dc <= 1'b1;
    end else if (en) begin
      last_dc <= gnt[1];
    end
  end

endmodule

// File: rtl/wt_l15_req_arb.sv
// Icache/dcache to L1.5 request arbiter: 1-cycle accept-to-valid, request held until header ack.
// Define WT_L15_REQ_ARB_SWAP_EN to byte-swap store/atomic data per 64-bit word at capture.
module wt_l15_req_arb
  import wt_cache_pkg::*;
#(
  parameter int PADDR_WIDTH = 56,
  parameter int DATA_WIDTH  = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     ic_req_valid_i,
  output logic                     ic_req_ready_o,
  input  logic [PADDR_WIDTH-1:0]   ic_req_paddr_i,
  input  logic                     ic_req_nc_i,
  input  logic [L1I_WAY_WIDTH-1:0] ic_req_way_i,
  input  logic [L15_TID_WIDTH-1:0] ic_req_tid_i,
  input  logic                     dc_req_valid_i,
  output logic                     dc_req_ready_o,
  input  dcache_out_t              dc_req_rtype_i,
  input  logic [1:0]               dc_req_size_i,
  input  logic [PADDR_WIDTH-1:0]   dc_req_paddr_i,
  input  logic [DATA_WIDTH-1:0]    dc_req_data_i,
  input  logic                     dc_req_nc_i,
  input  logic [L1D_WAY_WIDTH-1:0] dc_req_way_i,
  input  logic [L15_TID_WIDTH-1:0] dc_req_tid_i,
  input  logic [3:0]               dc_req_amo_op_i,
  output logic                     l15_val_o,
  input  logic                     l15_req_ack_i,
  output l15_reqtypes_t            l15_rqtype_o,
  output logic [2:0]               l15_size_o,
  output logic [PADDR_WIDTH-1:0]   l15_address_o,
  output logic [DATA_WIDTH-1:0]    l15_data_o,
  output logic                     l15_nc_o,
  output logic [L15_TID_WIDTH-1:0] l15_threadid_o,
  output logic [L15_WAY_WIDTH-1:0] l15_l1rplway_o,
  output logic [3:0]               l15_amo_op_o
);

  arb_state_t                 state;
  logic [1:0]                 gnt;
  logic                       accept;
  logic                       slot_free;
  logic                       dc_is_load;
  logic [DATA_WIDTH-1:0]      dc_data;
  l15_reqtypes_t              nxt_rqtype;
  logic [2:0]                 nxt_size;
  logic [PADDR_WIDTH-1:0]     nxt_address;
  logic [DATA_WIDTH-1:0]      nxt_data;
  logic                       nxt_nc;
  logic [L15_TID_WIDTH-1:0]   nxt_threadid;
  logic [L15_WAY_WIDTH-1:0]   nxt_l1rplway;
  logic [3:0]                 nxt_amo_op;

  rr_arb_2 u_rr_arb_2 (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .req    ({dc_req_valid_i, ic_req_valid_i}),
    .en     (accept),
    .gnt    (gnt)
  );

  // Ack only frees the slot while a request is held; readies stay low in reset.
  assign slot_free      = (state == ARB_IDLE) | l15_req_ack_i;
  assign ic_req_ready_o = rst_ni & slot_free & gnt[0];
  assign dc_req_ready_o = rst_ni & slot_free & gnt[1];
  assign accept         = ic_req_ready_o | dc_req_ready_o;
  assign dc_is_load     = (dc_req_rtype_i == DCACHE_LOAD_REQ);

  always_comb begin
    dc_data = dc_req_data_i;
`ifdef WT_L15_REQ_ARB_SWAP_EN
    for (int w = 0; w < DATA_WIDTH / 64; w++) begin
      dc_data[w*64 +: 64] = swendian64(dc_req_data_i[w*64 +: 64]);
    end
`endif
  end

  always_comb begin
    nxt_rqtype   = L15_LOAD_RQ;
    nxt_size     = {1'b0, dc_req_size_i};
    nxt_address  = dc_req_paddr_i;
    nxt_data     = dc_is_load ? '0 : dc_data;
    nxt_nc       = dc_req_nc_i;
    nxt_threadid = dc_req_tid_i;
    nxt_l1rplway = L15_WAY_WIDTH'(dc_req_way_i);
    nxt_amo_op   = dc_is_load ? 4'h0 : dc_req_amo_op_i;
    case (dc_req_rtype_i)
      DCACHE_STORE_REQ:  nxt_rqtype = L15_STORE_RQ;
      DCACHE_LOAD_REQ:   nxt_rqtype = L15_LOAD_RQ;
      DCACHE_ATOMIC_REQ: nxt_rqtype = L15_ATOMIC_RQ;
      DCACHE_INT_REQ:    nxt_rqtype = L15_INT_RQ;
    endcase
    if (gnt[0]) begin
      nxt_rqtype   = L15_IMISS_RQ;
      nxt_size     = 3'b111;
      nxt_address  = ic_req_paddr_i;
      nxt_data     = '0;
      nxt_nc       = ic_req_nc_i;
      nxt_threadid = ic_req_tid_i;
      nxt_l1rplway = L15_WAY_WIDTH'(ic_req_way_i);
      nxt_amo_op   = 4'h0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= ARB_IDLE;
      l15_val_o      <= 1'b0;
      l15_rqtype_o   <= L15_LOAD_RQ;
      l15_size_o     <= '0;
      l15_address_o  <= '0;
      l15_data_o     <= '0;
      l15_nc_o       <= 1'b0;
      l15_threadid_o <= '0;
      l15_l1rplway_o <= '0;
      l15_amo_op_o   <= '0;
    end else if (accept) begin
      state          <= ARB_HOLD;
      l15_val_o      <= 1'b1;
      l15_rqtype_o   <= nxt_rqtype;
      l15_size_o     <= nxt_size;
      l15_address_o  <= nxt_address;
      l15_data_o     <= nxt_data;
      l15_nc_o       <= nxt_nc;
      l15_threadid_o <= nxt_threadid;
      l15_l1rplway_o <= nxt_l1rplway;
      l15_amo_op_o   <= nxt_amo_op;
    end else if (state == ARB_HOLD && l15_req_ack_i) begin
      state          <= ARB_IDLE;
      l15_val_o      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wt_l15_req_arb.sv
// Directed-vector bench for wt_l15_req_arb with a queue scoreboard checked by a negedge monitor.
module tb_wt_l15_req_arb;
  import wt_cache_pkg::*;

  typedef struct packed {
    logic [4:0]  rqtype;
    logic [2:0]  size;
    logic [55:0] addr;
    logic [63:0] data;
    logic        nc;
    logic [1:0]  tid;
    logic [2:0]  way;
    logic [3:0]  amo;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ic_valid = 1'b0, ic_ready, ic_nc = 1'b0;
  logic [55:0] ic_paddr = '0;
  logic [1:0]  ic_way = '0, ic_tid = '0;
  logic        dc_valid = 1'b0, dc_ready, dc_nc = 1'b0;
  dcache_out_t dc_rtype = DCACHE_STORE_REQ;
  logic [1:0]  dc_size = '0, dc_way = '0, dc_tid = '0;
  logic [55:0] dc_paddr = '0;
  logic [63:0] dc_data = '0;
  logic [3:0]  dc_amo = '0;
  logic        l15_val, l15_ack = 1'b0, l15_nc;
  logic [4:0]  l15_rqtype;
  logic [2:0]  l15_size, l15_way;
  logic [55:0] l15_addr;
  logic [63:0] l15_data;
  logic [1:0]  l15_tid;
  logic [3:0]  l15_amo;

  exp_t exp_q[$];
  int   n_chk = 0;
  int   n_fail = 0;
  logic mon_en = 1'b0;
  int   ic_k = 0;
  int   dc_k = 0;

  always #5 clk = ~clk;

  wt_l15_req_arb dut (
    .clk_i(clk), .rst_ni(rst_n),
    .ic_req_valid_i(ic_valid), .ic_req_ready_o(ic_ready), .ic_req_paddr_i(ic_paddr),
    .ic_req_nc_i(ic_nc), .ic_req_way_i(ic_way), .ic_req_tid_i(ic_tid),
    .dc_req_valid_i(dc_valid), .dc_req_ready_o(dc_ready), .dc_req_rtype_i(dc_rtype),
    .dc_req_size_i(dc_size), .dc_req_paddr_i(dc_paddr), .dc_req_data_i(dc_data),
    .dc_req_nc_i(dc_nc), .dc_req_way_i(dc_way), .dc_req_tid_i(dc_tid), .dc_req_amo_op_i(dc_amo),
    .l15_val_o(l15_val), .l15_req_ack_i(l15_ack), .l15_rqtype_o(l15_rqtype),
    .l15_size_o(l15_size), .l15_address_o(l15_addr), .l15_data_o(l15_data),
    .l15_nc_o(l15_nc), .l15_threadid_o(l15_tid), .l15_l1rplway_o(l15_way), .l15_amo_op_o(l15_amo)
  );

  function automatic exp_t mk(input logic [4:0] rq, input logic [2:0] sz, input logic [55:0] a,
                              input logic [63:0] d, input logic nc, input logic [1:0] tid,
                              input logic [2:0] way, input logic [3:0] amo);
    exp_t e;
    e.rqtype = rq; e.size = sz; e.addr = a; e.data = d;
    e.nc = nc; e.tid = tid; e.way = way; e.amo = amo;
    return e;
  endfunction

  function automatic logic [63:0] exp_dat(input logic [63:0] d);
`ifdef WT_L15_REQ_ARB_SWAP_EN
    return {<<8{d}};
`else
    return d;
`endif
  endfunction

  task automatic check(input string name, input logic [137:0] act, input logic [137:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  function automatic exp_t act_bundle();
    return {l15_rqtype, l15_size, l15_addr, l15_data, l15_nc, l15_tid, l15_way, l15_amo};
  endfunction

  // Compare the head entry every cycle the request is presented; retire it on ack.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (ic_ready || dc_ready) check("ready_onehot", 138'(ic_ready & dc_ready), 138'(0));
      if (l15_val) begin
        if (exp_q.size() == 0) begin
          check("unexpected_val", 138'(l15_val), 138'(0));
        end else begin
          check("l15_req", act_bundle(), exp_q[0]);
          if (l15_ack) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rdy(input bit dc, input string name);
    int k = 0;
    #1;
    while (!(dc ? dc_ready : ic_ready) && k < 50) begin
      @(posedge clk);
      #2;
      k++;
    end
    check({name, "_rdy"}, 138'(dc ? dc_ready : ic_ready), 138'(1));
  endtask

  task automatic send_dc(input dcache_out_t rt, input logic [1:0] sz, input logic [55:0] a,
                         input logic [63:0] d, input logic [3:0] amo, input exp_t e,
                         input string name);
    dc_rtype = rt; dc_size = sz; dc_paddr = a; dc_data = d; dc_amo = amo;
    dc_nc = 1'b1; dc_way = 2'b10; dc_tid = 2'b01; dc_valid = 1'b1;
    wait_rdy(1'b1, name);
    exp_q.push_back(e);
    tick();
    dc_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state, with an icache request already pending.
    ic_valid = 1'b1; ic_paddr = 56'h8000_0040; ic_nc = 1'b0; ic_way = 2'b11; ic_tid = 2'b10;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_val", 138'(l15_val), 138'(0));
    check("rst_readies", 138'({ic_ready, dc_ready}), 138'(0));
    check("rst_fields", act_bundle(), 138'(0));
    mon_en = 1'b1;

    // First request after release: ready in cycle 0, valid in cycle 1.
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    check("ic_first_rdy", 138'(ic_ready), 138'(1));
    exp_q.push_back(mk(5'b10000, 3'b111, 56'h8000_0040, 64'h0, 1'b0, 2'b10, 3'b011, 4'h0));
    tick();
    ic_valid = 1'b0;
    check("val_cycle1", 138'(l15_val), 138'(1));
    l15_ack = 1'b1;
    tick();
    l15_ack = 1'b0;
    check("val_drop", 138'(l15_val), 138'(0));

    // Both sources valid, ack every cycle: icache was last, so dcache leads.
    for (int c = 0; c < 4; c++) begin
      if (c % 2 == 0)
        exp_q.push_back(mk(5'b00001, 3'b011, 56'h2000 + 56'(c / 2 * 8),
                           exp_dat(64'hD0D0_0000_0000_0000 + 64'(c / 2)), 1'b1, 2'b01, 3'b010, 4'h0));
      else
        exp_q.push_back(mk(5'b10000, 3'b111, 56'h1000 + 56'(c / 2 * 64), 64'h0, 1'b0, 2'b10,
                           3'b011, 4'h0));
    end
    l15_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      ic_paddr = 56'h1000 + 56'(ic_k * 64);
      dc_rtype = DCACHE_STORE_REQ; dc_size = 2'b11; dc_paddr = 56'h2000 + 56'(dc_k * 8);
      dc_data = 64'hD0D0_0000_0000_0000 + 64'(dc_k); dc_amo = 4'h0;
      dc_nc = 1'b1; dc_way = 2'b10; dc_tid = 2'b01;
      ic_valid = 1'b1; dc_valid = 1'b1;
      #1;
      check("alt_dc_rdy", 138'(dc_ready), 138'(c % 2 == 0));
      check("alt_ic_rdy", 138'(ic_ready), 138'(c % 2 == 1));
      if (c > 0) check("alt_no_bubble", 138'(l15_val), 138'(1));
      @(posedge clk); #1;
      if (c % 2 == 0) dc_k++; else ic_k++;
    end
    ic_valid = 1'b0; dc_valid = 1'b0;
    check("alt_last_val", 138'(l15_val), 138'(1));
    tick();
    l15_ack = 1'b0;
    check("alt_drained", 138'(l15_val), 138'(0));

    // Store held without ack; a short-lived icache valid must not be taken.
    send_dc(DCACHE_STORE_REQ, 2'b11, 56'h0000_0100, 64'h0011223344556677, 4'h0,
`ifdef WT_L15_REQ_ARB_SWAP_EN
            mk(5'b00001, 3'b011, 56'h0000_0100, 64'h7766554433221100, 1'b1, 2'b01, 3'b010, 4'h0),
`else
            mk(5'b00001, 3'b011, 56'h0000_0100, 64'h0011223344556677, 1'b1, 2'b01, 3'b010, 4'h0),
`endif
            "store");
    ic_valid = 1'b1; ic_paddr = 56'h5555;
    #1;
    check("hold_no_ic_rdy", 138'(ic_ready), 138'(0));
    tick();
    ic_valid = 1'b0;
    repeat (4) tick();
    l15_ack = 1'b1;
    tick();
    l15_ack = 1'b0;
    check("store_retired", 138'(l15_val), 138'(0));

    // Atomic, load and interrupt mappings; ack high while idle is ignored.
    l15_ack = 1'b1;
    send_dc(DCACHE_ATOMIC_REQ, 2'b11, 56'h3000_0008, 64'hDEADBEEF_CAFEF00D, 4'h3,
            mk(5'b00110, 3'b011, 56'h3000_0008, exp_dat(64'hDEADBEEF_CAFEF00D), 1'b1, 2'b01,
               3'b010, 4'h3), "atomic");
    send_dc(DCACHE_LOAD_REQ, 2'b10, 56'h3000_0010, 64'h1234, 4'h5,
            mk(5'b00000, 3'b010, 56'h3000_0010, 64'h0, 1'b1, 2'b01, 3'b010, 4'h0), "load");
    send_dc(DCACHE_INT_REQ, 2'b01, 56'h3000_0020, 64'h0102_0304_0506_0708, 4'h0,
            mk(5'b01001, 3'b001, 56'h3000_0020, exp_dat(64'h0102_0304_0506_0708), 1'b1, 2'b01,
               3'b010, 4'h0), "int");
    tick();
    l15_ack = 1'b0;
    check("maps_drained", 138'(l15_val), 138'(0));

    // Reset while a request is held: discarded, never replayed.
    ic_paddr = 56'h4000; ic_valid = 1'b1;
    wait_rdy(1'b0, "pre_rst");
    exp_q.push_back(mk(5'b10000, 3'b111, 56'h4000, 64'h0, 1'b0, 2'b10, 3'b011, 4'h0));
    tick();
    ic_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    check("rst_async_val", 138'(l15_val), 138'(0));
    check("rst_async_fields", act_bundle(), 138'(0));
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_replay", 138'(l15_val), 138'(0));
    end

    // After reset the tie goes to icache again.
    ic_paddr = 56'h6000; ic_valid = 1'b1;
    dc_rtype = DCACHE_STORE_REQ; dc_paddr = 56'h7000; dc_valid = 1'b1;
    #1;
    check("post_rst_ic_wins", 138'({ic_ready, dc_ready}), 138'(2'b10));
    exp_q.push_back(mk(5'b10000, 3'b111, 56'h6000, 64'h0, 1'b0, 2'b10, 3'b011, 4'h0));
    tick();
    ic_valid = 1'b0; dc_valid = 1'b0;
    l15_ack = 1'b1;
    tick();
    l15_ack = 1'b0;
    repeat (2) tick();
    check("queue_drained", 138'(exp_q.size()), 138'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
